// File: rtl/nn_fp_pkg.sv
// Shared FP32 constants, scan FSM encoding and NaN detection for the classifier stages.
package nn_fp_pkg;

    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;
    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == FP_EXP_MAX) && (x[22:0] != '0);
    endfunction

endpackage

// File: rtl/fp_gt.sv
// Combinational FP32 strict greater-than (a > b) with NaN never winning and +0 == -0.
module fp_gt
    import nn_fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt
);

    logic        a_nan, b_nan;
    logic [30:0] a_mag, b_mag;

    assign a_nan = is_nan(a);
    assign b_nan = is_nan(b);
    assign a_mag = a[30:0];
    assign b_mag = b[30:0];

    always_comb begin
        gt = 1'b0;
        if (a_nan) begin
            gt = 1'b0;
        end else if (b_nan) begin
            // a NaN incumbent yields to any real value
            gt = 1'b1;
        end else if ((a_mag == '0) && (b_mag == '0)) begin
            gt = 1'b0;
        end else if (a[31] != b[31]) begin
            gt = ~a[31];
        end else if (!a[31]) begin
            gt = a_mag > b_mag;
        end else begin
            gt = a_mag < b_mag;
        end
    end

endmodule

// File: rtl/softmax_argmax.sv
// Captures a softmax probability vector and scans it serially with one comparator
// to report the winning class index, its value and whether any element was NaN.
module softmax_argmax
    import nn_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM        = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [NUM*DATA_WIDTH-1:0] data_in,
    output logic                      busy,
    output logic                      out_valid,
    output logic [IDX_WIDTH-1:0]      class_idx,
    output logic [DATA_WIDTH-1:0]     max_value,
    output logic                      nan_seen
);

    state_e                             state_q, state_d;
    logic [NUM-1:0][DATA_WIDTH-1:0]     data_q, data_d;
    logic [DATA_WIDTH-1:0]              best_q, best_d;
    logic [IDX_WIDTH-1:0]               best_idx_q, best_idx_d;
    logic [IDX_WIDTH-1:0]               ptr_q, ptr_d;
    logic                               nan_q, nan_d;
    logic                               out_valid_q, out_valid_d;
    logic [IDX_WIDTH-1:0]               class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0]              max_value_q, max_value_d;
    logic                               nan_seen_q, nan_seen_d;

    logic [DATA_WIDTH-1:0] cur;
    logic                  cur_gt;

    assign cur = data_q[ptr_q];

    fp_gt u_gt (
        .a  (cur),
        .b  (best_q),
        .gt (cur_gt)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        ptr_d       = ptr_q;
        nan_d       = nan_q;
        out_valid_d = 1'b0;
        class_idx_d = class_idx_q;
        max_value_d = max_value_q;
        nan_seen_d  = nan_seen_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d     = data_in;
                    best_d     = data_in[DATA_WIDTH-1:0];
                    best_idx_d = '0;
                    ptr_d      = IDX_WIDTH'(1);
                    nan_d      = is_nan(data_in[DATA_WIDTH-1:0]);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                // strictly greater keeps the lowest index on ties
                if (cur_gt) begin
                    best_d     = cur;
                    best_idx_d = ptr_q;
                end
                nan_d = nan_q | is_nan(cur);
                ptr_d = ptr_q + IDX_WIDTH'(1);
                if (ptr_q == IDX_WIDTH'(NUM-1)) state_d = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                class_idx_d = best_idx_q;
                max_value_d = best_q;
                nan_seen_d  = nan_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            best_q      <= '0;
            best_idx_q  <= '0;
            ptr_q       <= '0;
            nan_q       <= 1'b0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            max_value_q <= '0;
            nan_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            ptr_q       <= ptr_d;
            nan_q       <= nan_d;
            out_valid_q <= out_valid_d;
            class_idx_q <= class_idx_d;
            max_value_q <= max_value_d;
            nan_seen_q  <= nan_seen_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign max_value = max_value_q;
    assign nan_seen  = nan_seen_q;

endmodule

// File: tb/tb_softmax_argmax.sv
// Scoreboard bench for softmax_argmax: directed vectors push expected results, a monitor checks each out_valid.
module tb_softmax_argmax;

    localparam int DW  = 32;
    localparam int NUM = 10;
    localparam int IW  = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [NUM*DW-1:0]   data_in = '0;
    logic                busy, out_valid, nan_seen;
    logic [IW-1:0]       class_idx;
    logic [DW-1:0]       max_value;

    softmax_argmax #(.DATA_WIDTH(DW), .NUM(NUM), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .busy      (busy),
        .out_valid (out_valid),
        .class_idx (class_idx),
        .max_value (max_value),
        .nan_seen  (nan_seen)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] val;
        logic        nan;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   zero_req = 0, zero_done = 0;
    int   tmo_req = 0, tmo_done = 0;
    logic [NUM-1:0][31:0] v;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: owns all comparisons and both counters.
    always @(negedge clk) begin
        if (zero_req != zero_done) begin
            zero_done = zero_req;
            checks++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || class_idx !== '0 ||
                max_value !== '0 || nan_seen !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: busy=%b out_valid=%b idx=%0d max=%h nan=%b, want all zero",
                         busy, out_valid, class_idx, max_value, nan_seen);
            end
        end
        if (tmo_req != tmo_done) begin
            tmo_done = tmo_req;
            checks++;
            errors++;
            $display("FAIL timeout: no out_valid within cycle budget");
        end
        if (!reset && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stray_out_valid: got pulse at cycle %0d, want none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                checks++;
                if (class_idx !== e.idx[IW-1:0]) begin
                    errors++;
                    $display("FAIL class_idx: got %0d want %0d", class_idx, e.idx);
                end
                checks++;
                if (max_value !== e.val) begin
                    errors++;
                    $display("FAIL max_value: got %h want %h", max_value, e.val);
                end
                checks++;
                if (nan_seen !== e.nan) begin
                    errors++;
                    $display("FAIL nan_seen: got %b want %b", nan_seen, e.nan);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL latency: out_valid at cycle %0d want %0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic fill(input logic [31:0] x);
        for (int i = 0; i < NUM; i++) v[i] = x;
    endtask

    // Issue v at the next edge; result expected after edge E+NUM.
    task automatic send(input int idx, input logic [31:0] val, input logic nan, input bit push);
        exp_t e;
        @(negedge clk);
        data_in  = v;
        in_valid = 1'b1;
        if (push) begin
            e.idx = idx; e.val = val; e.nan = nan; e.cyc = cyc + 1 + NUM;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            tmo_req++;
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input int idx, input logic [31:0] val, input logic nan);
        send(idx, val, nan, 1'b1);
        wait_done();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 zero_req++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        fill(32'h3CCCCCCD); v[0] = 32'h3DCCCCCD; v[1] = 32'h3D4CCCCD; v[3] = 32'h3F19999A;
        run(3, 32'h3F19999A, 1'b0);
        fill(32'h3DCCCCCD); v[2] = 32'h3F000000; v[7] = 32'h3F000000;
        run(2, 32'h3F000000, 1'b0);
        fill(32'h3DCCCCCD);
        run(0, 32'h3DCCCCCD, 1'b0);
        fill(32'hBF800000); v[0] = 32'h80000000; v[1] = 32'h00000000;
        run(0, 32'h80000000, 1'b0);
        fill(32'hBF800000); v[5] = 32'hBDCCCCCD;
        run(5, 32'hBDCCCCCD, 1'b0);
        fill(32'h3E800000); v[0] = 32'h7FC00000; v[4] = 32'h3F800000;
        run(4, 32'h3F800000, 1'b1);
        fill(32'h7FC00000);
        run(0, 32'h7FC00000, 1'b1);
        fill(32'h7F7FFFFF); v[9] = 32'h7F800000;
        run(9, 32'h7F800000, 1'b0);
        fill(32'h00000001); v[6] = 32'h00000002;
        run(6, 32'h00000002, 1'b0);
        fill(32'h00000000); v[8] = 32'h3F800000; v[9] = 32'hFFC00000;
        run(8, 32'h3F800000, 1'b1);

        // in_valid during the scan and in the DONE cycle must both be dropped
        fill(32'h3CCCCCCD); v[0] = 32'h3DCCCCCD; v[1] = 32'h3D4CCCCD; v[3] = 32'h3F19999A;
        send(3, 32'h3F19999A, 1'b0, 1'b1);
        fill(32'h3DCCCCCD); v[9] = 32'h3F800000;
        repeat (2) @(negedge clk);
        send(0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        send(0, 0, 1'b0, 1'b0);
        wait_done();
        repeat (12) @(negedge clk);

        // back-to-back at the minimum spacing of NUM+1 clocks
        fill(32'h3DCCCCCD); v[9] = 32'h3F800000;
        send(9, 32'h3F800000, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        fill(32'h3DCCCCCD); v[1] = 32'h3F000000;
        send(1, 32'h3F000000, 1'b0, 1'b1);
        wait_done();

        // reset after edge E+4 aborts the scan and clears the outputs
        fill(32'h3DCCCCCD); v[7] = 32'h3F800000;
        send(0, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 zero_req++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        fill(32'h3E800000); v[6] = 32'h3F400000;
        run(6, 32'h3F400000, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
